// File: rtl/rfile_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package rfile_pkg;

  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 64;  // must equal 2**ADDR_W

  typedef logic [ADDR_W-1:0]   reg_addr_t;
  typedef logic [DATA_W-1:0]   reg_data_t;
  typedef logic [NUM_REGS-1:0] reg_vec_t;

  function automatic reg_vec_t reg_onehot(input reg_addr_t addr);
    reg_vec_t v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rfile_wb_arbiter_if.sv
// Writeback requesters, issue/decode hazard inputs and register-file write port.
interface rfile_wb_if;
  import rfile_pkg::*;

  logic      Req0Valid;
  logic      Req0Ready;
  reg_addr_t Req0RD;
  reg_data_t Req0Data;
  logic      Req1Valid;
  logic      Req1Ready;
  reg_addr_t Req1RD;
  reg_data_t Req1Data;
  logic      IssueValid;
  reg_addr_t IssueRD;
  reg_addr_t RS;
  reg_addr_t RT;
  logic      Stall;
  logic      RegWrite;
  reg_addr_t RD;
  reg_data_t DataIN;
  logic      FwdRS;
  logic      FwdRT;

  modport master (
    output Req0Valid, Req0RD, Req0Data, Req1Valid, Req1RD, Req1Data,
           IssueValid, IssueRD, RS, RT,
    input  Req0Ready, Req1Ready, Stall, RegWrite, RD, DataIN, FwdRS, FwdRT
  );

  modport slave (
    input  Req0Valid, Req0RD, Req0Data, Req1Valid, Req1RD, Req1Data,
           IssueValid, IssueRD, RS, RT,
    output Req0Ready, Req1Ready, Stall, RegWrite, RD, DataIN, FwdRS, FwdRT
  );

endinterface

// File: rtl/rfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the priority pointer flips to the other side after any grant.
module rr_arb2 (
  input  logic Clock,
  input  logic Reset_n,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);

  logic prio1;  // 1: requester 1 wins a tie

  assign grant0 = valid0 & (~valid1 | ~prio1);
  assign grant1 = valid1 & (~valid0 |  prio1);

  // NOTE: non-blocking assignment so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      prio1 <= 1'b0;
    end else if (grant0) begin
      prio1 <= 1'b1;
    end else if (grant1) begin
      prio1 <= 1'b0;
    end
  end

endmodule

// File: rtl/rfile_wb_arbiter.sv
// Register-file write-port controller: round-robin writeback arbitration, registered
// write port and pending-write scoreboard with RAW/WAW stall. RFILE_WB_FWD_EN enables forwarding.
module rfile_wb_arbiter
  import rfile_pkg::*;
(
  input  logic Clock,
  input  logic Reset_n,
  rfile_wb_if.slave bus
);

  logic      grant0, grant1;
  logic      reg_write;
  reg_addr_t wr_addr;
  reg_data_t wr_data;
  reg_vec_t  pending;
  reg_vec_t  set_vec, clr_vec;
  logic      stall, fwd_rs, fwd_rt, rs_pend, rt_pend;

  rr_arb2 u_arb (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .valid0 (bus.Req0Valid),
    .valid1 (bus.Req1Valid),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign bus.Req0Ready = grant0;
  assign bus.Req1Ready = grant1;

  // Output stage: address/data hold when nothing is granted.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      reg_write <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      reg_write <= grant0 | grant1;
      if (grant0) begin
        wr_addr <= bus.Req0RD;
        wr_data <= bus.Req0Data;
      end else if (grant1) begin
        wr_addr <= bus.Req1RD;
        wr_data <= bus.Req1Data;
      end
    end
  end

  assign bus.RegWrite = reg_write;
  assign bus.RD       = wr_addr;
  assign bus.DataIN   = wr_data;

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (bus.IssueValid && !stall) set_vec = reg_onehot(bus.IssueRD);
    if (reg_write)                clr_vec = reg_onehot(wr_addr);
  end

  // NOTE: the scoreboard is a plain flop vector and must be reset; stale pending bits would deadlock decode.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_vec) | set_vec;  // set wins over clear
    end
  end

`ifdef RFILE_WB_FWD_EN
  assign fwd_rs  = reg_write && (wr_addr == bus.RS);
  assign fwd_rt  = reg_write && (wr_addr == bus.RT);
  // A source being committed this cycle is served by the forward path instead of stalling.
  assign rs_pend = pending[bus.RS] & ~fwd_rs;
  assign rt_pend = pending[bus.RT] & ~fwd_rt;
`else
  assign fwd_rs  = 1'b0;
  assign fwd_rt  = 1'b0;
  assign rs_pend = pending[bus.RS];
  assign rt_pend = pending[bus.RT];
`endif

  assign stall     = rs_pend | rt_pend | pending[bus.IssueRD];
  assign bus.Stall = stall;
  assign bus.FwdRS = fwd_rs;
  assign bus.FwdRT = fwd_rt;

endmodule

// File: tb/tb_rfile_wb_arbiter.sv
// Self-checking bench for rfile_wb_arbiter: scoreboard of expected register-file writes
// plus per-scenario directed checks of grants, stall and forwarding.
module tb_rfile_wb_arbiter;
  import rfile_pkg::*;

  typedef struct packed {
    reg_addr_t rd;
    reg_data_t data;
  } wr_t;

  logic Clock   = 1'b0;
  logic Reset_n = 1'b0;
  logic mon_en  = 1'b0;
  int   compared   = 0;
  int   mismatched = 0;

  rfile_wb_if bus ();

  rfile_wb_arbiter dut (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  // Reference model state
  wr_t       exp_q[$];
  logic      m_ptr;
  reg_vec_t  m_pend;
  logic      m_rw;
  reg_addr_t m_rd;
  logic      m_g0, m_g1, m_stall, m_fwd_rs, m_fwd_rt;

  always_comb begin
    m_g0 = bus.Req0Valid & (!bus.Req1Valid | !m_ptr);
    m_g1 = bus.Req1Valid & (!bus.Req0Valid |  m_ptr);
`ifdef RFILE_WB_FWD_EN
    m_fwd_rs = m_rw && (m_rd == bus.RS);
    m_fwd_rt = m_rw && (m_rd == bus.RT);
`else
    m_fwd_rs = 1'b0;
    m_fwd_rt = 1'b0;
`endif
    m_stall = (m_pend[bus.RS] & !m_fwd_rs) | (m_pend[bus.RT] & !m_fwd_rt) | m_pend[bus.IssueRD];
  end

  always @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      m_ptr  <= 1'b0;
      m_pend <= '0;
      m_rw   <= 1'b0;
      m_rd   <= '0;
      exp_q.delete();
    end else begin
      if (m_g0) begin
        exp_q.push_back('{rd: bus.Req0RD, data: bus.Req0Data});
        m_ptr <= 1'b1;
        m_rd  <= bus.Req0RD;
      end else if (m_g1) begin
        exp_q.push_back('{rd: bus.Req1RD, data: bus.Req1Data});
        m_ptr <= 1'b0;
        m_rd  <= bus.Req1RD;
      end
      m_rw <= m_g0 | m_g1;
      if (m_rw) m_pend[m_rd] <= 1'b0;
      if (bus.IssueValid && !m_stall) m_pend[bus.IssueRD] <= 1'b1;
    end
  end

  // Scoreboard consumer: inputs are stable at the falling edge.
  always @(negedge Clock) begin
    if (mon_en && Reset_n) begin
      if (exp_q.size() > 0) begin
        wr_t w;
        w = exp_q.pop_front();
        compared++;
        if (bus.RegWrite !== 1'b1 || bus.RD !== w.rd || bus.DataIN !== w.data) begin
          mismatched++;
          $display("FAIL wr_port: got we=%b rd=%0d data=%h, want we=1 rd=%0d data=%h",
                   bus.RegWrite, bus.RD, bus.DataIN, w.rd, w.data);
        end
      end else begin
        compared++;
        if (bus.RegWrite !== 1'b0) begin
          mismatched++;
          $display("FAIL wr_idle: got we=%b, want 0", bus.RegWrite);
        end
      end
      compared++;
      if (bus.Stall !== m_stall || bus.FwdRS !== m_fwd_rs || bus.FwdRT !== m_fwd_rt) begin
        mismatched++;
        $display("FAIL hazard: got stall=%b fwd=%b%b, want stall=%b fwd=%b%b",
                 bus.Stall, bus.FwdRS, bus.FwdRT, m_stall, m_fwd_rs, m_fwd_rt);
      end
      compared++;
      if (bus.Req0Ready !== m_g0 || bus.Req1Ready !== m_g1) begin
        mismatched++;
        $display("FAIL grants: got %b%b, want %b%b", bus.Req0Ready, bus.Req1Ready, m_g0, m_g1);
      end
    end
  end

  task automatic next();
    @(negedge Clock);
    #2;
  endtask

  task automatic clear_inputs();
    bus.Req0Valid = 0; bus.Req0RD = '0; bus.Req0Data = '0;
    bus.Req1Valid = 0; bus.Req1RD = '0; bus.Req1Data = '0;
    bus.IssueValid = 0; bus.IssueRD = '0; bus.RS = '0; bus.RT = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    Reset_n = 1'b0;
    repeat (3) next();
    compared++;
    if (bus.RegWrite !== 1'b0 || bus.RD !== '0 || bus.DataIN !== '0 || bus.Stall !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: we=%b rd=%0d data=%h stall=%b, want all 0",
               bus.RegWrite, bus.RD, bus.DataIN, bus.Stall);
    end
    Reset_n = 1'b1;
    mon_en  = 1'b1;
    next();
    // Mid-run reset with pending[5] set and a grant in flight
    bus.IssueValid = 1; bus.IssueRD = 6'd5;
    next();
    bus.IssueValid = 0; bus.IssueRD = '0; bus.RS = 6'd5;
    #1;
    compared++;
    if (bus.Stall !== 1'b1) begin
      mismatched++;
      $display("FAIL pre_reset_stall: got %b, want 1", bus.Stall);
    end
    bus.Req0Valid = 1; bus.Req0RD = 6'd6; bus.Req0Data = 32'h1234_5678;
    @(posedge Clock);
    #1;
    bus.Req0Valid = 0;
    Reset_n = 1'b0;
    #1;
    compared++;
    if (bus.RegWrite !== 1'b0 || bus.Stall !== 1'b0 || bus.RD !== '0 || bus.DataIN !== '0) begin
      mismatched++;
      $display("FAIL midrun_reset: we=%b stall=%b rd=%0d data=%h, want 0 0 0 0",
               bus.RegWrite, bus.Stall, bus.RD, bus.DataIN);
    end
    next();
    Reset_n = 1'b1;
    next();
    bus.Req0Valid = 1; bus.Req1Valid = 1; bus.Req0RD = 6'd20; bus.Req1RD = 6'd21;
    #1;
    compared++;
    if (bus.Req0Ready !== 1'b1 || bus.Req1Ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_ptr: got %b%b, want 10", bus.Req0Ready, bus.Req1Ready);
    end
    next();
    clear_inputs();
    next();
  endtask

  task automatic test_single();
    bus.Req0Valid = 1; bus.Req0RD = 6'd3; bus.Req0Data = 32'hDEAD_BEEF;
    #1;
    compared++;
    if (bus.Req0Ready !== 1'b1 || bus.Req1Ready !== 1'b0) begin
      mismatched++;
      $display("FAIL single_ready: got %b%b, want 10", bus.Req0Ready, bus.Req1Ready);
    end
    next();
    bus.Req0Valid = 0;
    #1;
    compared++;
    if (bus.RegWrite !== 1'b1 || bus.RD !== 6'd3 || bus.DataIN !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("FAIL single_write: got we=%b rd=%0d data=%h, want 1 3 deadbeef",
               bus.RegWrite, bus.RD, bus.DataIN);
    end
    next();
    compared++;
    if (bus.RegWrite !== 1'b0 || bus.RD !== 6'd3 || bus.DataIN !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("FAIL single_idle: got we=%b rd=%0d data=%h, want 0 3 deadbeef (held)",
               bus.RegWrite, bus.RD, bus.DataIN);
    end
  endtask

  task automatic test_contention();
    // Pointer sits at Req1 after the previous Req0 grant; one Req1 grant returns it to Req0.
    bus.Req1Valid = 1; bus.Req1RD = 6'd2; bus.Req1Data = 32'hA5A5_0000;
    #1;
    compared++;
    if (bus.Req1Ready !== 1'b1) begin
      mismatched++;
      $display("FAIL lone_req1: got %b, want 1", bus.Req1Ready);
    end
    next();
    for (int i = 0; i < 4; i++) begin
      bus.Req0Valid = 1; bus.Req0RD = 6'd1; bus.Req0Data = 32'h1000_0000 + 32'(i);
      bus.Req1Valid = 1; bus.Req1RD = 6'd2; bus.Req1Data = 32'h2000_0000 + 32'(i);
      #1;
      compared++;
      if (bus.Req0Ready !== ((i % 2) == 0) || bus.Req1Ready !== ((i % 2) == 1)) begin
        mismatched++;
        $display("FAIL contention[%0d]: got %b%b, want %b%b", i, bus.Req0Ready, bus.Req1Ready,
                 (i % 2) == 0, (i % 2) == 1);
      end
      next();
    end
    clear_inputs();
    next();
  endtask

  task automatic test_raw();
    bus.IssueValid = 1; bus.IssueRD = 6'd7;
    next();
    bus.IssueValid = 0; bus.IssueRD = 6'd0; bus.RS = 6'd7;
    #1;
    compared++;
    if (bus.Stall !== 1'b1) begin
      mismatched++;
      $display("FAIL raw_stall: got %b, want 1", bus.Stall);
    end
    bus.Req0Valid = 1; bus.Req0RD = 6'd7; bus.Req0Data = 32'h0000_0777;
    next();
    bus.Req0Valid = 0;
    #1;
    compared++;
`ifdef RFILE_WB_FWD_EN
    if (bus.Stall !== 1'b0 || bus.FwdRS !== 1'b1) begin
      mismatched++;
      $display("FAIL raw_commit: got stall=%b fwd=%b, want 0 1", bus.Stall, bus.FwdRS);
    end
`else
    if (bus.Stall !== 1'b1 || bus.FwdRS !== 1'b0) begin
      mismatched++;
      $display("FAIL raw_commit: got stall=%b fwd=%b, want 1 0", bus.Stall, bus.FwdRS);
    end
`endif
    next();
    compared++;
    if (bus.Stall !== 1'b0) begin
      mismatched++;
      $display("FAIL raw_release: got %b, want 0", bus.Stall);
    end
    clear_inputs();
    next();
  endtask

  task automatic test_set_clear();
    // pending[9]=1: issue on the commit edge is a WAW stall and is dropped.
    bus.IssueValid = 1; bus.IssueRD = 6'd9;
    next();
    bus.IssueValid = 0;
    bus.Req0Valid = 1; bus.Req0RD = 6'd9; bus.Req0Data = 32'h9999_0001;
    next();
    bus.Req0Valid = 0;
    bus.IssueValid = 1; bus.IssueRD = 6'd9;
    #1;
    compared++;
    if (bus.Stall !== 1'b1) begin
      mismatched++;
      $display("FAIL waw_on_commit: got %b, want 1", bus.Stall);
    end
    next();
    bus.IssueValid = 0;
    #1;
    compared++;
    if (bus.Stall !== 1'b0) begin
      mismatched++;
      $display("FAIL pend9_cleared: got %b, want 0", bus.Stall);
    end
    // pending[9]=0: issue and commit on one edge, the set wins.
    bus.Req0Valid = 1; bus.Req0RD = 6'd9; bus.Req0Data = 32'h9999_0002;
    next();
    bus.Req0Valid = 0;
    bus.IssueValid = 1;
    #1;
    compared++;
    if (bus.Stall !== 1'b0) begin
      mismatched++;
      $display("FAIL set_clear_nostall: got %b, want 0", bus.Stall);
    end
    next();
    bus.IssueValid = 0;
    #1;
    compared++;
    if (bus.Stall !== 1'b1) begin
      mismatched++;
      $display("FAIL set_wins: got %b, want 1", bus.Stall);
    end
    bus.Req1Valid = 1; bus.Req1RD = 6'd9; bus.Req1Data = 32'h9999_0003;
    next();
    bus.Req1Valid = 0;
    next();
    compared++;
    if (bus.Stall !== 1'b0) begin
      mismatched++;
      $display("FAIL set_wins_release: got %b, want 0", bus.Stall);
    end
    clear_inputs();
    next();
  endtask

  task automatic test_waw();
    bus.IssueValid = 1; bus.IssueRD = 6'd12;
    next();
    #1;
    compared++;
    if (bus.Stall !== 1'b1) begin
      mismatched++;
      $display("FAIL waw_stall: got %b, want 1", bus.Stall);
    end
    next();
    bus.IssueValid = 0;
    bus.Req0Valid = 1; bus.Req0RD = 6'd12; bus.Req0Data = 32'h0000_0C0C;
    next();
    bus.Req0Valid = 0;
    #1;
    compared++;
    if (bus.Stall !== 1'b1) begin
      mismatched++;
      $display("FAIL waw_commit_cycle: got %b, want 1", bus.Stall);
    end
    next();
    compared++;
    if (bus.Stall !== 1'b0) begin
      mismatched++;
      $display("FAIL waw_release: got %b, want 0", bus.Stall);
    end
    clear_inputs();
    next();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      bus.Req0Valid = 1'($urandom_range(0, 1));
      bus.Req1Valid = 1'($urandom_range(0, 1));
      bus.Req0RD    = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      bus.Req1RD    = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      bus.Req0Data  = $urandom;
      bus.Req1Data  = $urandom;
      bus.RS        = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      bus.RT        = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      bus.IssueRD   = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      bus.IssueValid = ($urandom_range(0, 3) == 0);
      #1;
      compared++;
      if (bus.Req0Ready && bus.Req1Ready) begin
        mismatched++;
        $display("FAIL b2b_both_ready[%0d]", i);
      end
      next();
    end
    clear_inputs();
    repeat (2) next();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_raw();
    test_set_clear();
    test_waw();
    test_back_to_back();
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d writes outstanding, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rfile_wb_arbiter.md
Name: rfile_wb_arbiter

Overview:
- Write-port controller for the 64x32 register file, which has one write port (RegWrite/RD/DataIN).
- Arbitrates two writeback requesters round-robin: Req0 is ALU writeback, Req1 is load writeback.
- Drives the register-file write port from a registered output stage.
- Keeps a 64-bit pending-write scoreboard and raises Stall on RAW and WAW hazards against RS, RT and IssueRD.

Parameters:
- ADDR_W, 6, register address width.
- DATA_W, 32, register data width.
- NUM_REGS, 64, scoreboard depth; must equal 2**ADDR_W.

Ports:
- Clock  in  1  single clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Req0Valid  in  1  ALU writeback request.
- Req0Ready  out  1  grant to Req0 (combinational).
- Req0RD  in  ADDR_W  Req0 destination register.
- Req0Data  in  DATA_W  Req0 write data.
- Req1Valid  in  1  load writeback request.
- Req1Ready  out  1  grant to Req1 (combinational).
- Req1RD  in  ADDR_W  Req1 destination register.
- Req1Data  in  DATA_W  Req1 write data.
- IssueValid  in  1  an instruction issues that will write IssueRD.
- IssueRD  in  ADDR_W  destination register of the issuing instruction.
- RS  in  ADDR_W  source register A of the instruction being decoded.
- RT  in  ADDR_W  source register B of the instruction being decoded.
- Stall  out  1  hazard; hold decode/issue.
- RegWrite  out  1  register-file write enable (registered).
- RD  out  ADDR_W  register-file write address (registered).
- DataIN  out  DATA_W  register-file write data (registered).
- FwdRS  out  1  forward DataIN onto the RS operand (feature only).
- FwdRT  out  1  forward DataIN onto the RT operand (feature only).

Behaviour:
- Reset (async, Reset_n=0):
  - RegWrite=0, RD=0, DataIN=0.
  - Priority pointer = Req0.
  - All 64 pending bits cleared.
  - Any in-flight grant is lost; requesters re-present after reset.
- Arbitration:
  - The output stage is never back-pressured.
  - If exactly one requester is valid, it is granted.
  - If both are valid, the one named by the priority pointer is granted.
  - ReqNReady = grant_N; it is never high without ReqNValid.
- Priority pointer: after any grant it moves to the other requester; with no grant it holds.
- Latency: a handshake at edge N (Valid & Ready) gives RegWrite=1, RD, DataIN valid during cycle N+1. The register file writes at the edge closing cycle N+1.
- No grant: RegWrite=0 next cycle; RD and DataIN hold their previous values.
- Scoreboard:
  - IssueValid & ~Stall sets pending[IssueRD] at the edge.
  - IssueValid while Stall=1 is ignored (no set).
  - RegWrite=1 clears pending[RD] at the edge (commit edge).
  - Set and clear of the same index on the same edge: set wins.
  - A commit to a non-pending register is legal and leaves the scoreboard unchanged.
- Stall = pending[RS] | pending[RT] | pending[IssueRD] (combinational; IssueRD term covers WAW).
- Stall drops the cycle after the commit edge. The register file samples RS/RT on the same edge, so a read issued after Stall drops returns the new value.
- No register is hardwired to zero; all 64 are tracked.

Optional Feature:
- Macro RFILE_WB_FWD_EN.
- Defined:
  - FwdRS = RegWrite & (RD==RS); FwdRT = RegWrite & (RD==RT).
  - A pending bit whose register is being committed this cycle is masked out of the RS/RT Stall terms.
  - This saves one stall cycle; decode muxes DataIN onto the operand.
  - The IssueRD term is not masked.
- Undefined: FwdRS=FwdRT=0 constantly; Stall is exactly as in Behaviour.

Decomposition:
- Package rfile_pkg: ADDR_W, DATA_W, NUM_REGS constants; typedef reg_addr_t [ADDR_W-1:0]; typedef reg_data_t [DATA_W-1:0].
- One sub-module, rr_arb2: 2-way round-robin arbiter with Clock, Reset_n, two valids in, two one-hot grants out, internal priority flop.
- Scoreboard, output stage and Stall logic stay in the top.

Test Plan:
- Reset: hold Reset_n=0 mid-run with pending[5]=1 and a grant in flight -> RegWrite=0, Stall=0 for RS=5, pointer=Req0 after release.
- Single requester: Req0Valid, Req0RD=3, Req0Data=0xDEADBEEF at edge N -> Req0Ready=1 in cycle N; RegWrite=1, RD=3, DataIN=0xDEADBEEF in cycle N+1; RegWrite=0 in N+2.
- Contention: both valid for 4 cycles (RD=1 and RD=2) -> grants alternate Req0, Req1, Req0, Req1; Ready never high for both at once.
- RAW stall: issue IssueRD=7; next cycle RS=7 -> Stall=1. Commit RD=7 -> Stall=0 the cycle after the commit edge (feature off), or during the commit cycle with FwdRS=1 (feature on).
- Simultaneous set and clear: commit RD=9 and IssueValid with IssueRD=9 on the same edge while pending[9]=1 -> this is the WAW-stall case, so IssueValid is ignored and pending[9] ends 0. Separately, with pending[9]=0, issue IssueRD=9 on the same edge as a commit to RD=9 -> pending[9]=1 (set wins).
- WAW: pending[12]=1, IssueValid with IssueRD=12 -> Stall=1, issue ignored; pending[12] clears only on commit of RD=12.
